lq_dispatch_alloc: RTL and testbench

- Load-queue side of the dispatch handshake, responding to the dispatch stage.
- Each cycle it advertises per-slot availability (lq_avail) and the assigned load-queue index (lq_idx) for up to WIDTH dispatching instructions.
- It allocates entries on dispatch, frees them in order on retire, and empties the speculative queue on squash.
- Sits between the dispatch bundle producer and the load queue storage; it owns the head/tail pointers.

---
 rtl/lq_dispatch_alloc_if.sv | 30 +++
 rtl/lq_dispatch_alloc.sv | 85 ++++++++
 tb/tb_lq_dispatch_alloc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lq_dispatch_alloc_if.sv
// Dispatch <-> load-queue allocation handshake.
// The master modport is the dispatch stage. The slave modport is the LQ allocator.
interface lq_dispatch_alloc_if #(
   parameter int WIDTH   = 3,
   parameter int LQ_SIZE = 8,
   parameter int IDX_W   = $clog2(LQ_SIZE),
   parameter int RET_W   = $clog2(WIDTH + 1),
   parameter int CNT_W   = $clog2(LQ_SIZE + 1)
);
   logic [WIDTH-1:0]       valid;
   logic [WIDTH-1:0]       is_load;
   logic [WIDTH-1:0]       lq_avail;
   logic [WIDTH*IDX_W-1:0] lq_idx;
   logic [RET_W-1:0]       retire_cnt;
   logic                   squash;
   logic [IDX_W-1:0]       head_idx;
   logic [CNT_W-1:0]       lq_count;
   logic                   lq_full;
   logic                   lq_empty;

   modport master (
      output valid, is_load, retire_cnt, squash,
      input  lq_avail, lq_idx, head_idx, lq_count, lq_full, lq_empty
   );

   modport slave (
      input  valid, is_load, retire_cnt, squash,
      output lq_avail, lq_idx, head_idx, lq_count, lq_full, lq_empty
   );
endinterface

// File: rtl/lq_dispatch_alloc.sv
// Load-queue allocator. It owns the head and tail pointers of the load queue.
// Each pointer carries one extra wrap bit. When the low bits match, the wrap bit
// tells a full queue apart from an empty one.
// The availability and index outputs depend only on registered state and is_load.
// They never depend on valid, so the dispatch stage cannot form a combinational
// loop through this block.
module lq_dispatch_alloc #(
   parameter int WIDTH   = 3,
   parameter int LQ_SIZE = 8
) (
   input  logic                clock,
   input  logic                reset,
   lq_dispatch_alloc_if.slave  dis
);
   localparam int IDX_W = $clog2(LQ_SIZE);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(LQ_SIZE + 1);

   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [PTR_W-1:0]       count;
   logic [PTR_W-1:0]       free;
   logic [PTR_W-1:0]       head_next;
   logic [PTR_W-1:0]       alloc_cnt;
   logic [WIDTH-1:0]       avail;
   logic [WIDTH*IDX_W-1:0] idx;

   assign count = tail_q - head_q;
   // A retire in the current cycle does not enlarge free. The space it releases
   // is seen on the next cycle.
   assign free  = PTR_W'(LQ_SIZE) - count;

   // Per-slot index and availability (prefix count of loads), plus the allocation count.
   always_comb begin
      logic [PTR_W-1:0] pre;
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      pre       = '0;
      avail     = '0;
      idx       = '0;
      alloc_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         idx[i*IDX_W +: IDX_W] = IDX_W'(tail_q + pre);
         avail[i] = !dis.is_load[i] || ((pre + PTR_W'(1)) <= free);
         if (dis.valid[i] && dis.is_load[i] && avail[i])
            alloc_cnt = alloc_cnt + PTR_W'(1);
         if (dis.is_load[i])
            pre = pre + PTR_W'(1);
      end
   end

   // Next pointers. Retire always advances head. Squash pulls tail back to the new head.
   always_comb begin
      head_next = head_q + PTR_W'(dis.retire_cnt);
      head_d    = head_next;
      tail_d    = dis.squash ? head_next : (tail_q + alloc_cnt);
   end

   // Pointer registers. Reset empties the queue immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of head_q/tail_q.
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign dis.lq_avail = avail;
   assign dis.lq_idx   = idx;
   assign dis.head_idx = head_q[IDX_W-1:0];
   assign dis.lq_count = CNT_W'(count);
   assign dis.lq_empty = (tail_q == head_q);
   assign dis.lq_full  = (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]) &&
                         (tail_q[IDX_W] != head_q[IDX_W]);

   // Protocol checks on the dispatch side.
   a_valid_prefix: assert property (@(posedge clock) disable iff (reset)
      (dis.valid & (dis.valid + WIDTH'(1))) == '0);
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      (dis.valid & dis.is_load & ~avail) == '0);
   a_retire_le_count: assert property (@(posedge clock) disable iff (reset)
      PTR_W'(dis.retire_cnt) <= count);
endmodule

// File: tb/tb_lq_dispatch_alloc.sv
// Directed bench for lq_dispatch_alloc.
// The driver applies each vector just after a rising edge and queues the expected outputs.
// The monitor pops the queue and compares on the following falling edge.
module tb_lq_dispatch_alloc;
   logic clock;
   logic reset;

   lq_dispatch_alloc_if #(.WIDTH(3), .LQ_SIZE(8)) dis ();

   lq_dispatch_alloc #(.WIDTH(3), .LQ_SIZE(8)) dut (
      .clock (clock),
      .reset (reset),
      .dis   (dis)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [2:0] avail;
      logic [8:0] idx;
      logic [3:0] cnt;
      logic [2:0] head;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [8:0] ix(input int a2, input int a1, input int a0);
      logic [2:0] b2, b1, b0;
      b2 = 3'(a2);
      b1 = 3'(a1);
      b0 = 3'(a0);
      return {b2, b1, b0};
   endfunction

   // Monitor: compare the DUT outputs with the oldest queued expectation.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, ".avail"}, 32'(dis.lq_avail), 32'(e.avail));
         check({e.name, ".idx"},   32'(dis.lq_idx),   32'(e.idx));
         check({e.name, ".count"}, 32'(dis.lq_count), 32'(e.cnt));
         check({e.name, ".head"},  32'(dis.head_idx), 32'(e.head));
         check({e.name, ".full"},  32'(dis.lq_full),  32'(e.cnt == 4'd8));
         check({e.name, ".empty"}, 32'(dis.lq_empty), 32'(e.cnt == 4'd0));
      end
   end

   task automatic drive(input logic [2:0] v, input logic [2:0] ld, input logic [1:0] rc, input logic sq);
      dis.valid      = v;
      dis.is_load    = ld;
      dis.retire_cnt = rc;
      dis.squash     = sq;
   endtask

   // Apply one vector after the next rising edge. The expected outputs reflect the state before that edge.
   task automatic step(input string nm, input logic [2:0] v, input logic [2:0] ld,
                       input logic [1:0] rc, input logic sq, input logic [2:0] ea,
                       input logic [8:0] ei, input logic [3:0] ec, input logic [2:0] eh);
      exp_t e;
      @(posedge clock);
      #1;
      drive(v, ld, rc, sq);
      e.name = nm; e.avail = ea; e.idx = ei; e.cnt = ec; e.head = eh;
      exp_q.push_back(e);
   endtask

   initial begin
      reset = 1'b1;
      drive(3'b000, 3'b111, 2'd0, 1'b0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      //    name        valid   load    rc sq  avail   idx          cnt hd
      step("reset",    3'b000, 3'b111, 0, 0, 3'b111, ix(2,1,0), 0, 0);
      step("fill0",    3'b111, 3'b111, 0, 0, 3'b111, ix(2,1,0), 0, 0);
      step("fill1",    3'b111, 3'b111, 0, 0, 3'b111, ix(5,4,3), 3, 0);
      step("near_full",3'b011, 3'b111, 0, 0, 3'b011, ix(0,7,6), 6, 0);
      step("full_ret", 3'b000, 3'b111, 2, 0, 3'b000, ix(2,1,0), 8, 0);
      step("after_ret",3'b011, 3'b111, 0, 0, 3'b011, ix(2,1,0), 6, 2);
      step("full_nold",3'b000, 3'b000, 3, 0, 3'b111, ix(2,2,2), 8, 2);
      step("mixed",    3'b111, 3'b101, 0, 0, 3'b111, ix(3,3,2), 5, 5);
      step("ret2",     3'b000, 3'b000, 2, 0, 3'b111, ix(4,4,4), 7, 5);
      step("squash",   3'b111, 3'b111, 1, 1, 3'b111, ix(6,5,4), 5, 7);
      step("post_sq",  3'b111, 3'b111, 0, 0, 3'b111, ix(2,1,0), 0, 0);
      step("ret_alloc",3'b111, 3'b111, 3, 0, 3'b111, ix(5,4,3), 3, 0);
      step("drain",    3'b000, 3'b000, 3, 0, 3'b111, ix(6,6,6), 3, 3);
      step("wrap",     3'b111, 3'b111, 0, 0, 3'b111, ix(0,7,6), 0, 6);
      step("post_wrap",3'b000, 3'b111, 0, 0, 3'b111, ix(3,2,1), 3, 6);

      // Reset in the middle of a cycle while retire, squash and dispatch are all active.
      step("mid_reset",3'b111, 3'b111, 1, 1, 3'b111, ix(2,1,0), 0, 0);
      #2 reset = 1'b1;
      @(negedge clock);
      #1;
      drive(3'b000, 3'b111, 2'd0, 1'b0);
      reset = 1'b0;
      step("post_rst", 3'b000, 3'b111, 0, 0, 3'b111, ix(2,1,0), 0, 0);

      // Wait, with a bounded budget, for the monitor to drain the queue.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
      #1;
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
